// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions: field widths and limits, time-bus bit offsets
// and the run/stop/clear FSM state encoding.
package stopwatch_pkg;

  localparam int CSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int TIME_W = CSEC_W + SEC_W + MIN_W + HOUR_W;

  localparam logic [CSEC_W-1:0] CSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  localparam int CSEC_LSB = 0;
  localparam int SEC_LSB  = 7;
  localparam int MIN_LSB  = 13;
  localparam int HOUR_LSB = 19;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_time_counter_tick_gen.sv
// Centisecond timebase divider. Counts 0..DIV-1 while enabled, holds its
// phase while disabled, zeroes on clear. o_tick is combinational and high in
// the same cycle the counter sits at DIV-1 (the wrap cycle).
module tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Next divider value; clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_tick = wrap;

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase and control: run/stop/clear FSM, cascaded
// csec/sec/min/hour counters and the packed 24-bit time bus.
// Optional lap freeze/release is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_btn_run_stop,
  input  logic        i_btn_clear,
  input  logic        i_btn_lap,
  output logic [23:0] o_time,
  output logic        o_running,
  output logic        o_tick,
  output logic        o_lap_active
);

  state_e state_q, state_d;

  logic [CSEC_W-1:0] csec_q, csec_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick;
  logic              tick_q;
  logic [TIME_W-1:0] live_time;

  tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (state_q == ST_RUN),
    .i_clr  (state_q == ST_CLEAR),
    .o_tick (tick)
  );

  // FSM next state: run_stop beats clear in STOP; CLEAR always returns to STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (i_btn_run_stop)   state_d = ST_RUN;
        else if (i_btn_clear) state_d = ST_CLEAR;
      end
      ST_RUN: begin
        if (i_btn_run_stop)   state_d = ST_STOP;
      end
      ST_CLEAR:               state_d = ST_STOP;
      default:                state_d = ST_STOP;
    endcase
  end

  // Cascaded field counters: each field carries into the next at its limit.
  always_comb begin
    csec_d = csec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (state_q == ST_CLEAR) begin
      csec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (tick) begin
      if (csec_q == CSEC_MAX) begin
        csec_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d  = '0;
            hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end else begin
        csec_d = csec_q + 1'b1;
      end
    end
  end

  // State, field and tick registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_STOP;
      csec_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      csec_q  <= csec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick;
    end
  end

  assign live_time[CSEC_LSB +: CSEC_W] = csec_q;
  assign live_time[SEC_LSB  +: SEC_W]  = sec_q;
  assign live_time[MIN_LSB  +: MIN_W]  = min_q;
  assign live_time[HOUR_LSB +: HOUR_W] = hour_q;

  assign o_running = (state_q == ST_RUN);
  assign o_tick    = tick_q;

`ifdef STOPWATCH_LAP_EN
  logic [TIME_W-1:0] lap_q, lap_d;
  logic              lap_active_q, lap_active_d;

  // Lap latch: first press in RUN freezes the display, any other press releases.
  always_comb begin
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    if (state_q == ST_CLEAR) begin
      lap_d        = '0;
      lap_active_d = 1'b0;
    end else if (i_btn_lap) begin
      if ((state_q == ST_RUN) && !lap_active_q) begin
        lap_d        = live_time;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end
  end

  // Lap register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else begin
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign o_time       = lap_active_q ? lap_q : live_time;
  assign o_lap_active = lap_active_q;
`else
  logic unused_lap;
  assign unused_lap   = i_btn_lap;
  assign o_time       = live_time;
  assign o_lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter at CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10).
// Stimulus pushes the expected o_time of every upcoming tick into exp_q; the
// monitor pops one entry per o_tick pulse and compares.
module tb_stopwatch_time_counter;

  logic        clk;
  logic        reset;
  logic        btn_rs;
  logic        btn_clr;
  logic        btn_lap;
  logic [23:0] o_time;
  logic        o_running;
  logic        o_tick;
  logic        o_lap_active;

  logic [23:0] exp_q[$];
  int          n_vec;
  int          n_err;
  int          tick_cnt;
  int          base;

  stopwatch_time_counter #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_btn_run_stop (btn_rs),
    .i_btn_clear    (btn_clr),
    .i_btn_lap      (btn_lap),
    .o_time         (o_time),
    .o_running      (o_running),
    .o_tick         (o_tick),
    .o_lap_active   (o_lap_active)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Time model: total centiseconds -> packed bus
  function automatic logic [23:0] pack(input int t);
    int h, m, s, c;
    h = (t / 360000) % 24;
    m = (t / 6000) % 60;
    s = (t / 100) % 60;
    c = t % 100;
    return {h[4:0], m[5:0], s[5:0], c[6:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks (entered and left on a negedge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic rs, input logic clr, input logic lap);
    btn_rs  = rs;
    btn_clr = clr;
    btn_lap = lap;
    @(negedge clk);
    btn_rs  = 1'b0;
    btn_clr = 1'b0;
    btn_lap = 1'b0;
  endtask

  task automatic push_ticks(input int start_t, input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(pack(start_t + i));
  endtask

  // Monitor / scoreboard: one expected entry per o_tick pulse
  always @(posedge clk) begin
    #1;
    if (o_tick) begin
      tick_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tick: got tick with o_time %0h, expected no tick", o_time);
      end else begin
        check("tick_time", o_time, exp_q.pop_front());
      end
    end
    assert (o_time[6:0] <= 7'd99 && o_time[12:7] <= 6'd59 &&
            o_time[18:13] <= 6'd59 && o_time[23:19] <= 5'd23)
      else $error("field out of range: %0h", o_time);
  end

  // Directed stimulus
  initial begin
    n_vec    = 0;
    n_err    = 0;
    tick_cnt = 0;
    reset    = 1'b0;
    btn_rs   = 1'b0;
    btn_clr  = 1'b0;
    btn_lap  = 1'b0;

    // 1. reset and idle
    step(3);
    check("rst_time", o_time, 0);
    check("rst_running", o_running, 0);
    check("rst_tick", o_tick, 0);
    check("rst_lap", o_lap_active, 0);
    reset = 1'b1;
    step(50);
    check("idle_ticks", tick_cnt, 0);
    check("idle_time", o_time, 0);

    // 2. one second of run
    base = tick_cnt;
    push_ticks(0, 100);
    press(1, 0, 0);
    check("run_entered", o_running, 1);
    step(1000);
    check("one_second", o_time, 24'h000080);
    check("one_second_running", o_running, 1);
    check("one_second_ticks", tick_cnt - base, 100);
    check("one_second_q_empty", exp_q.size(), 0);

    // 4a. stop at csec=37 with divider=4, then clear
    push_ticks(100, 37);
    step(373);
    press(1, 0, 0);
    check("stop_running", o_running, 0);
    check("stop_time", o_time, pack(137));
    check("stop_div", dut.u_tick_gen.cnt_q, 4);
    base = tick_cnt;
    step(20);
    check("stop_hold_time", o_time, pack(137));
    check("stop_hold_ticks", tick_cnt - base, 0);
    press(0, 1, 0);
    step(1);
    check("clear_time", o_time, 0);
    check("clear_div", dut.u_tick_gen.cnt_q, 0);
    check("clear_running", o_running, 0);

    // 4b. run_stop + clear together in STOP: run wins, no clear
    push_ticks(0, 5);
    press(1, 0, 0);
    step(50);
    press(1, 0, 0);
    check("stop2_time", o_time, pack(5));
    press(1, 1, 0);
    check("rs_clr_running", o_running, 1);
    check("rs_clr_time", o_time, pack(5));
    check("rs_clr_div", dut.u_tick_gen.cnt_q, 1);
    push_ticks(5, 1);
    step(9);
    check("rs_clr_tick_time", o_time, pack(6));

    // 5. clear ignored in RUN; stop at divider=6, resume keeps phase
    press(0, 1, 0);
    check("run_clear_running", o_running, 1);
    check("run_clear_time", o_time, pack(6));
    step(4);
    press(1, 0, 0);
    check("phase_stop_div", dut.u_tick_gen.cnt_q, 6);
    check("phase_stop_running", o_running, 0);
    base = tick_cnt;
    step(500);
    check("phase_hold_ticks", tick_cnt - base, 0);
    check("phase_hold_time", o_time, pack(6));
    push_ticks(6, 1);
    press(1, 0, 0);
    step(3);
    check("resume_no_early_tick", tick_cnt - base, 0);
    step(1);
    check("resume_tick_at_4", tick_cnt - base, 1);
    check("resume_time", o_time, pack(7));
    press(1, 0, 0);
    press(0, 1, 0);
    step(1);
    check("clear2_time", o_time, 0);

    // 3. full wrap from 23:59:59.98
    force dut.hour_q = 5'd23;
    force dut.min_q  = 6'd59;
    force dut.sec_q  = 6'd59;
    force dut.csec_q = 7'd98;
    step(1);
    release dut.hour_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.csec_q;
    step(1);
    check("preload_time", o_time, pack(8639998));
    push_ticks(8639998, 2);
    press(1, 0, 0);
    step(19);
    check("pre_wrap_time", o_time, pack(8639999));
    step(1);
    check("wrap_time", o_time, 0);
    check("wrap_q_empty", exp_q.size(), 0);

    // 6. lap (or lap ignored), then reset mid-run
    press(1, 0, 0);
    press(0, 1, 0);
    step(1);
    push_ticks(0, 20);
    press(1, 0, 0);
    step(200);
    check("pre_lap_time", o_time, pack(20));
`ifdef STOPWATCH_LAP_EN
    for (int i = 0; i < 30; i++) exp_q.push_back(pack(20));
    press(0, 0, 1);
    check("lap_active", o_lap_active, 1);
    check("lap_time", o_time, pack(20));
    step(299);
    check("lap_frozen_time", o_time, pack(20));
    check("lap_frozen_active", o_lap_active, 1);
    check("lap_q_empty", exp_q.size(), 0);
    press(0, 0, 1);
    check("lap_release_active", o_lap_active, 0);
    check("lap_release_time", o_time, pack(50));
    press(0, 0, 1);
    check("lap2_active", o_lap_active, 1);
`else
    push_ticks(20, 10);
    press(0, 0, 1);
    check("lap_ignored_active", o_lap_active, 0);
    check("lap_ignored_time", o_time, pack(20));
    step(99);
    check("lap_ignored_live", o_time, pack(30));
    check("lap_ignored_active2", o_lap_active, 0);
`endif
    reset = 1'b0;
    step(1);
    check("midrst_time", o_time, 0);
    check("midrst_running", o_running, 0);
    check("midrst_tick", o_tick, 0);
    check("midrst_lap", o_lap_active, 0);
    reset = 1'b1;
    base = tick_cnt;
    step(30);
    check("post_rst_ticks", tick_cnt - base, 0);
    check("post_rst_time", o_time, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
